// File: rtl/prach_fcw_ctrl.sv
// rtl/prach_fcw_ctrl.sv - PRACH DDC FCW shadow/active tables with frame-aligned atomic commit
module prach_fcw_ctrl #(
  parameter int N_CC    = 3,
  parameter int N_CHN   = 8,
  parameter int FCW_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_wr_en,
  input  logic [4:0]       csr_wr_addr,
  input  logic [FCW_W-1:0] csr_wr_data,
  input  logic             csr_commit,
  input  logic             csr_err_clr,
  input  logic             sync_in,
  output logic [FCW_W-1:0] ctrl_fcw [N_CC][N_CHN],
  output logic             fcw_update,
  output logic             csr_busy,
  output logic [1:0]       csr_err,
  output logic [7:0]       commit_cnt
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ARMED} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             upd_q, upd_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [FCW_W-1:0] shadow_q [N_CC][N_CHN];
  logic [FCW_W-1:0] active_q [N_CC][N_CHN];

  logic [1:0] wr_cc;
  logic [2:0] wr_chn;
  logic       cc_ok;
  logic       wr_ok;
  logic       wr_drop;
  logic       apply;
  logic       tmo_hit;

  // Event decode: the shadow is only writable in IDLE so the snapshot stays frozen while armed
  assign wr_cc   = csr_wr_addr[4:3];
  assign wr_chn  = csr_wr_addr[2:0];
  assign cc_ok   = (32'(wr_cc) < N_CC);
  assign wr_ok   = csr_wr_en && (state_q == IDLE) && cc_ok;
  assign wr_drop = csr_wr_en && !wr_ok;
  assign apply   = (state_q == ARMED) && sync_in;
  assign tmo_hit = (state_q == ARMED) && !sync_in && (tmo_cnt_q == TMO_LAST);

  // State, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      upd_q     <= 1'b0;
      err_q     <= 2'b00;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state: commit arms; apply wins over timeout; commit while armed is ignored
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (csr_commit) state_d = ARMED;
      end
      ARMED: begin
        if (apply || tmo_hit) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  // Output next values: update pulse, sticky errors (new error beats clear), apply counter
  always_comb begin
    upd_d    = apply;
    err_d[0] = wr_drop | (err_q[0] & ~csr_err_clr);
    err_d[1] = tmo_hit | (err_q[1] & ~csr_err_clr);
    cnt_d    = cnt_q + 8'(apply);
  end

  // Shadow table: CSR writes land here, one entry per accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CC; i++)
        for (int j = 0; j < N_CHN; j++)
          shadow_q[i][j] <= '0;
    end else if (wr_ok) begin
      shadow_q[wr_cc][wr_chn] <= csr_wr_data;
    end
  end

  // Active table: whole-table copy on the frame boundary so all NCOs retune together
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CC; i++)
        for (int j = 0; j < N_CHN; j++)
          active_q[i][j] <= '0;
    end else if (apply) begin
      active_q <= shadow_q;
    end
  end

  assign ctrl_fcw   = active_q;
  assign fcw_update = upd_q;
  assign csr_busy   = (state_q == ARMED);
  assign csr_err    = err_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_prach_fcw_ctrl.sv
// tb/tb_prach_fcw_ctrl.sv - self-checking bench for prach_fcw_ctrl
module tb_prach_fcw_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_wr_en = 1'b0;
  logic [4:0]  csr_wr_addr = '0;
  logic [15:0] csr_wr_data = '0;
  logic        csr_commit = 1'b0;
  logic        csr_err_clr = 1'b0;
  logic        sync_in = 1'b0;
  logic [15:0] ctrl_fcw [3][8];
  logic        fcw_update;
  logic        csr_busy;
  logic [1:0]  csr_err;
  logic [7:0]  commit_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prach_fcw_ctrl #(
    .N_CC(3), .N_CHN(8), .FCW_W(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_commit(csr_commit), .csr_err_clr(csr_err_clr), .sync_in(sync_in),
    .ctrl_fcw(ctrl_fcw), .fcw_update(fcw_update), .csr_busy(csr_busy),
    .csr_err(csr_err), .commit_cnt(commit_cnt)
  );

  // Behavioural model: pending commit tracked as an absolute deadline cycle
  longint      cyc = 0;
  bit          mdl_on = 0;
  bit          m_armed = 0;
  longint      m_deadline = 0;
  logic [15:0] m_shadow [3][8];
  logic [15:0] m_active [3][8];
  bit          m_upd = 0;
  logic [1:0]  m_err = 2'b00;
  int          m_cnt = 0;

  always @(posedge clk) begin
    int cc;
    int ch;
    bit drop;
    bit tmo;
    cyc++;
    if (rst) begin
      mdl_on = 1; m_armed = 0; m_upd = 0; m_err = 2'b00; m_cnt = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 8; j++) begin
          m_shadow[i][j] = 16'h0;
          m_active[i][j] = 16'h0;
        end
    end else begin
      cc = int'(csr_wr_addr[4:3]);
      ch = int'(csr_wr_addr[2:0]);
      drop = csr_wr_en && (m_armed || cc >= 3);
      tmo = 0;
      m_upd = 0;
      if (m_armed) begin
        if (sync_in) begin
          m_active = m_shadow;
          m_upd = 1;
          m_cnt = (m_cnt + 1) % 256;
          m_armed = 0;
        end else if (cyc == m_deadline) begin
          m_armed = 0;
          tmo = 1;
        end
      end else begin
        if (csr_wr_en && cc < 3) m_shadow[cc][ch] = csr_wr_data;
        if (csr_commit) begin
          m_armed = 1;
          m_deadline = cyc + TMO;
        end
      end
      if (csr_err_clr) m_err = 2'b00;
      m_err = m_err | {tmo, drop};
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    int bi;
    int bj;
    bit tbl_ok;
    if (mdl_on) begin
      n_chk++;
      if (csr_busy !== m_armed) begin
        n_fail++; $display("FAIL busy: got %b expected %b at cyc %0d", csr_busy, m_armed, cyc);
      end
      n_chk++;
      if (fcw_update !== m_upd) begin
        n_fail++; $display("FAIL fcw_update: got %b expected %b at cyc %0d", fcw_update, m_upd, cyc);
      end
      n_chk++;
      if (csr_err !== m_err) begin
        n_fail++; $display("FAIL csr_err: got %b expected %b at cyc %0d", csr_err, m_err, cyc);
      end
      n_chk++;
      if (commit_cnt !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL commit_cnt: got %0d expected %0d at cyc %0d", commit_cnt, m_cnt, cyc);
      end
      tbl_ok = 1; bi = 0; bj = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 8; j++)
          if (tbl_ok && ctrl_fcw[i][j] !== m_active[i][j]) begin
            tbl_ok = 0; bi = i; bj = j;
          end
      n_chk++;
      if (!tbl_ok) begin
        n_fail++;
        $display("FAIL ctrl_fcw[%0d][%0d]: got %h expected %h at cyc %0d",
                 bi, bj, ctrl_fcw[bi][bj], m_active[bi][bj], cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    csr_wr_en = 1'b1; csr_wr_addr = a; csr_wr_data = d;
    tick();
    csr_wr_en = 1'b0;
  endtask

  task automatic commit();
    csr_commit = 1'b1;
    tick();
    csr_commit = 1'b0;
  endtask

  task automatic sync();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
  endtask

  task automatic err_clear();
    csr_err_clr = 1'b1;
    tick();
    csr_err_clr = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      csr_wr_en = 1'($urandom); csr_wr_addr = 5'($urandom); csr_wr_data = 16'($urandom);
      csr_commit = 1'($urandom); csr_err_clr = 1'($urandom); sync_in = 1'($urandom);
      tick();
    end
    chk("rst_busy", 32'(csr_busy), 0);
    chk("rst_upd", 32'(fcw_update), 0);
    chk("rst_err", 32'(csr_err), 0);
    chk("rst_cnt", 32'(commit_cnt), 0);
    chk("rst_fcw12", 32'(ctrl_fcw[1][2]), 0);
    rst = 1'b0; csr_wr_en = 0; csr_commit = 0; csr_err_clr = 0; sync_in = 0;
    for (int i = 0; i < 10; i++) begin
      sync_in = ~sync_in;
      tick();
      chk("post_rst_no_upd", 32'(fcw_update), 0);
    end
    sync_in = 1'b0;
    idle(2);

    // Basic commit
    wr(5'h0A, 16'h1234);
    commit();
    chk("basic_busy", 32'(csr_busy), 1);
    idle(4);
    sync();
    chk("basic_fcw12", 32'(ctrl_fcw[1][2]), 32'h1234);
    chk("basic_upd", 32'(fcw_update), 1);
    chk("basic_cnt", 32'(commit_cnt), 1);
    chk("basic_fcw00", 32'(ctrl_fcw[0][0]), 0);
    chk("basic_idle", 32'(csr_busy), 0);
    tick();
    chk("basic_upd_once", 32'(fcw_update), 0);

    // Frozen snapshot
    commit();
    wr(5'h00, 16'hBEEF);
    sync();
    chk("frozen_fcw00", 32'(ctrl_fcw[0][0]), 0);
    chk("frozen_err", 32'(csr_err), 1);
    chk("frozen_cnt", 32'(commit_cnt), 2);
    err_clear();
    chk("frozen_clr", 32'(csr_err), 0);

    // Bad address
    wr(5'h18, 16'h5555);
    chk("badaddr_err", 32'(csr_err), 1);
    err_clear();
    commit();
    sync();
    chk("badaddr_fcw12", 32'(ctrl_fcw[1][2]), 32'h1234);
    chk("badaddr_cnt", 32'(commit_cnt), 3);

    // Timeout with sync withheld
    commit();
    idle(TMO - 1);
    chk("tmo_still_busy", 32'(csr_busy), 1);
    tick();
    chk("tmo_busy", 32'(csr_busy), 0);
    chk("tmo_err", 32'(csr_err), 2);
    chk("tmo_cnt", 32'(commit_cnt), 3);
    chk("tmo_fcw12", 32'(ctrl_fcw[1][2]), 32'h1234);
    err_clear();

    // Sync on the final armed cycle applies
    commit();
    idle(TMO - 1);
    sync();
    chk("tmo_edge_upd", 32'(fcw_update), 1);
    chk("tmo_edge_err", 32'(csr_err), 0);
    chk("tmo_edge_cnt", 32'(commit_cnt), 4);

    // Commit coincident with sync does not apply
    csr_commit = 1'b1; sync_in = 1'b1;
    tick();
    csr_commit = 1'b0; sync_in = 1'b0;
    chk("coinc_busy", 32'(csr_busy), 1);
    chk("coinc_upd", 32'(fcw_update), 0);
    idle(2);
    sync();
    chk("coinc_later_upd", 32'(fcw_update), 1);
    chk("coinc_cnt", 32'(commit_cnt), 5);

    // Write and commit in the same cycle
    csr_wr_en = 1'b1; csr_wr_addr = 5'h17; csr_wr_data = 16'hA5A5; csr_commit = 1'b1;
    tick();
    csr_wr_en = 1'b0; csr_commit = 1'b0;
    sync();
    chk("wrcommit_fcw27", 32'(ctrl_fcw[2][7]), 32'hA5A5);

    // Reset while armed
    commit();
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_armed_busy", 32'(csr_busy), 0);
    chk("rst_armed_fcw27", 32'(ctrl_fcw[2][7]), 0);
    sync();
    chk("rst_armed_no_upd", 32'(fcw_update), 0);
    chk("rst_armed_cnt", 32'(commit_cnt), 0);

    // 256 applies wrap the counter
    for (int i = 0; i < 256; i++) begin
      commit();
      sync();
      if (i == 254) chk("wrap_255", 32'(commit_cnt), 255);
    end
    chk("wrap_0", 32'(commit_cnt), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
